regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Round-robin arbiter that shares the single register-file write port among NUM_REQ writeback requesters, e.g. ALU writeback, load writeback and debug write.
- Contains a clear sequencer that zeroes all registers one per cycle on command.
- Drops writes to register 0 when PROTECT_R0=1, so the MIPS $zero register stays zero.
- Drives the register file's RegWrite, write_addr and write_data inputs from registered outputs.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, registers walked by the clear sequence
PROTECT_R0, 1, when 1, granted writes to address 0 are discarded

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-high reset
req  input  NUM_REQ  per-requester write request
req_addr  input  ADDR_W*NUM_REQ  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  input  DATA_W*NUM_REQ  packed data; requester i at [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as req
clear_start  input  1  pulse: begin zeroing all registers
busy  output  1  high while the clear sequence runs
clear_done  output  1  one-cycle pulse after the last clear write is issued
RegWrite  output  1  registered write enable to the register file
write_addr  output  ADDR_W  registered write address
write_data  output  DATA_W  registered write data
r0_drop  output  1  registered one-cycle pulse: a granted write to address 0 was discarded

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0, clear counter = 0.
  - RegWrite = 0, write_addr = 0, write_data = 0.
  - busy = 0, clear_done = 0, r0_drop = 0, gnt = 0.
- Reset mid-clear aborts the sequence without a clear_done pulse.
- States:
  - IDLE: arbitrate requesters.
  - CLEAR: sequencer owns the port.
- IDLE, no clear_start:
  - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - gnt[winner]=1 combinationally in that cycle.
  - At the next edge:
    - RegWrite<=1, write_addr<=req_addr[winner], write_data<=req_data[winner].
    - rr_ptr<=(winner+1) mod NUM_REQ.
  - No req: RegWrite<=0, rr_ptr unchanged, write_addr/write_data hold.
- Handshake:
  - Requester holds req, addr and data stable until it sees gnt=1.
  - The write is accepted at that edge.
  - The requester may present a new request or deassert in the following cycle.
  - Exactly one grant per cycle; gnt never asserts without req.
- Latency:
  - Grant cycle t → RegWrite high during cycle t+1.
  - The register file captures the write at the end of t+1.
- PROTECT_R0=1 and granted address = 0:
  - The grant still occurs and rr_ptr still advances.
  - RegWrite<=0 and r0_drop<=1 for that cycle.
- IDLE and clear_start=1:
  - Clear takes priority; gnt=0 in that cycle.
  - Next edge: state<=CLEAR, counter<=0, RegWrite<=0.
- CLEAR:
  - gnt=0 always; busy=1.
  - Each edge: RegWrite<=1, write_addr<=counter, write_data<=0, counter++.
  - Register 0 is written with zero regardless of PROTECT_R0.
  - After issuing address NUM_REGS-1: state<=IDLE, clear_done<=1 for one cycle, counter<=0.
  - The sequence takes NUM_REGS cycles of writes.
  - Arbitration resumes in the cycle clear_done is high.
- clear_start while busy is ignored.
- Pending req during CLEAR stays pending (no loss) and is arbitrated from the current rr_ptr after return to IDLE.
- rr_ptr wraps from NUM_REQ-1 to 0.

Test Plan:
- Reset asserted mid-cycle with req=3'b111 → all outputs 0 immediately (async), gnt=0 while reset high.
- Single requester: req=3'b010, addr=7, data=0xDEADBEEF → gnt=3'b010 same cycle; next cycle RegWrite=1, write_addr=7, write_data=0xDEADBEEF.
- Fairness: req=3'b111 held 6 cycles, each requester dropping req for one cycle after its grant → grant order 0,1,2,0,1,2; no requester starved.
- R0 protection: req[0] with addr=0, data=5 → gnt[0]=1; next cycle RegWrite=0, r0_drop=1; rr_ptr advances to 1.
- Clear:
  - Stimulus: clear_start pulse with req[2] asserted, addr=3, data=9.
  - During clear: 32 consecutive writes, addr 0..31, data 0; busy=1; gnt=0.
  - Completion: clear_done pulses once; req[2] granted that cycle; register 3 then holds 9.
- Reset abort: reset pulse at clear address 10 → busy=0, no clear_done; a new clear_start restarts from address 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port, with a one-register-per-cycle
// clear sequencer and optional discard of writes to register 0.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int PROTECT_R0 = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      clear_start,
  output logic                      busy,
  output logic                      clear_done,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [DATA_W-1:0]         write_data,
  output logic                      r0_drop
);

  localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned NREQ  = NUM_REQ;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   next_ptr;
  logic [CNT_W-1:0]   counter;
  logic               found;
  logic               last;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  assign last     = (counter == CNT_W'(NUM_REGS - 1));
  assign busy     = (state == CLEAR);
  assign sel_addr = req_addr[winner*ADDR_W +: ADDR_W];
  assign sel_data = req_data[winner*DATA_W +: DATA_W];
  assign next_ptr = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // Scan starts at rr_ptr and wraps; a pending clear_start or reset suppresses the grant.
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    if (state == IDLE && !clear_start && !reset) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req[idx]) begin
          found  = 1'b1;
          winner = PTR_W'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found) gnt[winner] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_start) state_next = CLEAR;
      CLEAR:   if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      counter    <= '0;
      RegWrite   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      clear_done <= 1'b0;
      r0_drop    <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      r0_drop    <= 1'b0;
      if (state == CLEAR) begin
        RegWrite   <= 1'b1;
        write_addr <= ADDR_W'(counter);
        write_data <= '0;
        if (last) begin
          clear_done <= 1'b1;
          counter    <= '0;
        end else begin
          counter <= counter + 1'b1;
        end
      end else if (clear_start) begin
        RegWrite <= 1'b0;
        counter  <= '0;
      end else if (found) begin
        rr_ptr <= next_ptr;
        // A protected r0 write is still granted but never reaches the register file.
        if (PROTECT_R0 != 0 && sel_addr == '0) begin
          RegWrite <= 1'b0;
          r0_drop  <= 1'b1;
        end else begin
          RegWrite   <= 1'b1;
          write_addr <= sel_addr;
          write_data <= sel_data;
        end
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table for arbitration, hand sequences
// for reset, clear, and clear abort.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  gnt;
  logic        clear_start;
  logic        busy;
  logic        clear_done;
  logic        RegWrite;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        r0_drop;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf [32];

  regfile_write_arbiter #(
    .NUM_REQ(3), .ADDR_W(5), .DATA_W(32), .NUM_REGS(32), .PROTECT_R0(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .RegWrite(RegWrite), .write_addr(write_addr), .write_data(write_data), .r0_drop(r0_drop)
  );

  always #5 clk = ~clk;

  // External register file model, written mid-cycle while the write is presented.
  always @(negedge clk) if (!reset && RegWrite) rf[write_addr] = write_data;

  typedef struct {
    logic [2:0]  req;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  gnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        drop;
  } vec_t;

  vec_t vt [13];

  function automatic vec_t mk(input logic [2:0] r, input logic [4:0] a0, a1, a2,
                              input logic [31:0] d0, d1, d2, input logic [2:0] g,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic dr);
    vec_t v;
    v.req = r; v.addr = {a2, a1, a0}; v.data = {d2, d1, d0};
    v.gnt = g; v.we = we; v.waddr = wa; v.wdata = wd; v.drop = dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 0);
    chk({tag, "_we"}, 64'(RegWrite), 0);
    chk({tag, "_waddr"}, 64'(write_addr), 0);
    chk({tag, "_wdata"}, 64'(write_data), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(clear_done), 0);
    chk({tag, "_drop"}, 64'(r0_drop), 0);
  endtask

  initial begin
    int n;
    bit seen;
    // rr_ptr after each vector: 2,2,0,1,2,0,1,2,0,1,2,1,1
    vt[0]  = mk(3'b010, 1, 7, 3, 'h11, 'hDEADBEEF, 'h33, 3'b010, 1, 7, 'hDEADBEEF, 0);
    vt[1]  = mk(3'b000, 1, 2, 3, 'h11, 'h22, 'h33, 3'b000, 0, 7, 'hDEADBEEF, 0);
    vt[2]  = mk(3'b100, 1, 2, 3, 'h11, 'h22, 'h33, 3'b100, 1, 3, 'h33, 0);
    vt[3]  = mk(3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 3'b001, 1, 1, 'h11, 0);
    vt[4]  = mk(3'b110, 1, 2, 3, 'h11, 'h22, 'h33, 3'b010, 1, 2, 'h22, 0);
    vt[5]  = mk(3'b101, 1, 2, 3, 'h11, 'h22, 'h33, 3'b100, 1, 3, 'h33, 0);
    vt[6]  = mk(3'b011, 1, 2, 3, 'h11, 'h22, 'h33, 3'b001, 1, 1, 'h11, 0);
    vt[7]  = mk(3'b110, 1, 2, 3, 'h11, 'h22, 'h33, 3'b010, 1, 2, 'h22, 0);
    vt[8]  = mk(3'b101, 1, 2, 3, 'h11, 'h22, 'h33, 3'b100, 1, 3, 'h33, 0);
    vt[9]  = mk(3'b001, 0, 2, 3, 'h5,  'h22, 'h33, 3'b001, 0, 3, 'h33, 1);
    vt[10] = mk(3'b011, 4, 5, 6, 'h44, 'h55, 'h66, 3'b010, 1, 5, 'h55, 0);
    vt[11] = mk(3'b001, 4, 5, 6, 'h44, 'h55, 'h66, 3'b001, 1, 4, 'h44, 0);
    vt[12] = mk(3'b000, 4, 5, 6, 'h44, 'h55, 'h66, 3'b000, 0, 4, 'h44, 0);

    reset = 1'b1; req = 3'b111; req_addr = '0; req_data = '0; clear_start = 1'b0;
    #2;
    chk_zero("por");
    step();
    chk_zero("por_clk");
    reset = 1'b0; req = '0;

    foreach (vt[i]) begin
      req = vt[i].req; req_addr = vt[i].addr; req_data = vt[i].data;
      #1;
      chk($sformatf("v%0d_gnt", i), 64'(gnt), 64'(vt[i].gnt));
      step();
      chk($sformatf("v%0d_we", i), 64'(RegWrite), 64'(vt[i].we));
      chk($sformatf("v%0d_waddr", i), 64'(write_addr), 64'(vt[i].waddr));
      chk($sformatf("v%0d_wdata", i), 64'(write_data), 64'(vt[i].wdata));
      chk($sformatf("v%0d_drop", i), 64'(r0_drop), 64'(vt[i].drop));
    end

    // Asynchronous reset in the middle of a cycle with a write on the port.
    req = 3'b111; req_addr = {5'd3, 5'd2, 5'd1}; req_data = {32'h33, 32'h22, 32'h11};
    step();
    chk("pre_rst_we", 64'(RegWrite), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("async_rst");
    step();
    reset = 1'b0;
    req = '0;
    step();

    // Clear with requester 2 pending; clear_start mid-clear must be ignored.
    req = 3'b100; req_addr = {5'd3, 5'd0, 5'd0}; req_data = {32'd9, 64'd0};
    clear_start = 1'b1;
    #1;
    chk("clr_start_gnt", 64'(gnt), 0);
    step();
    clear_start = 1'b0;
    chk("clr_first_we", 64'(RegWrite), 0);
    for (int k = 0; k < 32; k++) begin
      clear_start = (k == 5);
      #1;
      chk($sformatf("clr%0d_busy", k), 64'(busy), 1);
      chk($sformatf("clr%0d_gnt", k), 64'(gnt), 0);
      step();
      chk($sformatf("clr%0d_we", k), 64'(RegWrite), 1);
      chk($sformatf("clr%0d_waddr", k), 64'(write_addr), 64'(k));
      chk($sformatf("clr%0d_wdata", k), 64'(write_data), 0);
      chk($sformatf("clr%0d_done", k), 64'(clear_done), (k == 31) ? 1 : 0);
    end
    clear_start = 1'b0;
    #1;
    chk("clr_end_busy", 64'(busy), 0);
    chk("clr_end_gnt", 64'(gnt), 3'b100);
    step();
    req = '0;
    chk("post_clr_done", 64'(clear_done), 0);
    chk("post_clr_we", 64'(RegWrite), 1);
    chk("post_clr_waddr", 64'(write_addr), 3);
    chk("post_clr_wdata", 64'(write_data), 9);
    step();
    chk("rf_r3", 64'(rf[3]), 9);
    chk("rf_r0", 64'(rf[0]), 0);
    chk("rf_r31", 64'(rf[31]), 0);

    // Reset while the clear is issuing address 10.
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    n = 0;
    while (!(RegWrite && write_addr == 5'd10) && n < 40) begin step(); n++; end
    chk("abort_reach10", 64'(write_addr), 10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_we", 64'(RegWrite), 0);
    step();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (clear_done || busy) seen = 1;
    end
    chk("abort_no_done", 64'(seen), 0);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    step();
    chk("restart_we", 64'(RegWrite), 1);
    chk("restart_waddr", 64'(write_addr), 0);
    n = 0;
    while (!clear_done && n < 40) begin step(); n++; end
    chk("restart_done", 64'(clear_done), 1);
    chk("restart_last_addr", 64'(write_addr), 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
